// File: rtl/serial_tcmp_array.sv
// NCH-lane word-framed serial pass/negate/abs stage. Words arrive LSB first and are
// buffered whole (the sign comes last), then replayed through the serial complement rule.

module serial_tcmp_array_chk #(
  parameter int NCH = 1
) (
  input logic           clk,
  input logic           rst,
  input logic           out_valid,
  input logic           out_sow,
  input logic           out_eow,
  input logic [NCH-1:0] out_ovf
);

  a_eow_valid: assert property (@(posedge clk) disable iff (!rst) out_eow |-> out_valid);
  a_sow_valid: assert property (@(posedge clk) disable iff (!rst) out_sow |-> out_valid);
  a_sow_eow:   assert property (@(posedge clk) disable iff (!rst) out_sow |-> !out_eow);
  a_ovf_eow:   assert property (@(posedge clk) disable iff (!rst) (|out_ovf) |-> out_eow);

endmodule

module serial_tcmp_array #(
  parameter int WIDTH = 32,
  parameter int NCH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_bit,
  input  logic             in_valid,
  input  logic             in_sow,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   out_bit,
  output logic             out_valid,
  output logic             out_sow,
  output logic             out_eow,
  output logic [NCH-1:0]   out_ovf,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic {CAP_IDLE = 1'b0, CAP_CAPT = 1'b1} cap_state_t;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_t;

  // capture stage: only bits 0..WIDTH-2 are held, the sign bit goes straight to transfer
  cap_state_t                  cap_state_r, cap_state_s;
  logic [CW-1:0]               cnt_r, cnt_s;
  logic [NCH-1:0][WIDTH-2:0]   cap_r, cap_s;
  logic [NCH-1:0]              lowzero_r, lowzero_s;
  logic [NCH-1:0][1:0]         mode_r, mode_s;
  logic                        xfer_s;
  logic                        abort_s;

  logic [NCH-1:0][WIDTH-1:0]   word_s;
  logic [NCH-1:0][WIDTH-2:0]   load_cap_s;
  logic [NCH-1:0]              word_neg_s;
  logic [NCH-1:0]              word_ovf_s;

  // output stage: bit 0 is emitted on transfer, the remaining WIDTH-1 bits wait here
  out_state_t                  out_state_r, out_state_s;
  logic [CW-1:0]               ocnt_r, ocnt_s;
  logic [NCH-1:0][WIDTH-2:0]   osh_r, osh_s;
  logic [NCH-1:0]              oneg_r, oneg_s;
  logic [NCH-1:0]              oovf_r, oovf_s;
  logic [NCH-1:0]              z_r, z_s;

  logic [NCH-1:0]              out_bit_r, out_bit_s;
  logic [NCH-1:0]              out_ovf_r, out_ovf_s;
  logic                        out_valid_r, out_valid_s;
  logic                        out_sow_r, out_sow_s;
  logic                        out_eow_r, out_eow_s;
  logic                        frame_err_r;

  // Per-lane word assembly and sign-dependent flags for the word completing this cycle
  always_comb begin
    for (int l = 0; l < NCH; l++) begin
      word_s[l]                 = {in_bit[l], cap_r[l]};
      load_cap_s[l]             = '0;
      load_cap_s[l][WIDTH-2]    = in_bit[l];
      word_neg_s[l] = (mode_r[l] == 2'b01) | ((mode_r[l] == 2'b10) & in_bit[l]);
      word_ovf_s[l] = word_neg_s[l] & in_bit[l] & lowzero_r[l];
    end
  end

  // Capture FSM next-state: framing, abort on early sow, transfer on the last bit
  always_comb begin
    cap_state_s = cap_state_r;
    cnt_s       = cnt_r;
    cap_s       = cap_r;
    lowzero_s   = lowzero_r;
    mode_s      = mode_r;
    xfer_s      = 1'b0;
    abort_s     = 1'b0;
    case (cap_state_r)
      CAP_IDLE: begin
        if (in_valid && in_sow) begin
          cap_state_s = CAP_CAPT;
          cnt_s       = CNT_ONE;
          cap_s       = load_cap_s;
          lowzero_s   = ~in_bit;
          for (int l = 0; l < NCH; l++) begin
            mode_s[l] = mode[2*l +: 2];
          end
        end else begin
          cap_state_s = CAP_IDLE;
        end
      end
      CAP_CAPT: begin
        if (in_valid && in_sow) begin
          abort_s   = 1'b1;
          cnt_s     = CNT_ONE;
          cap_s     = load_cap_s;
          lowzero_s = ~in_bit;
          for (int l = 0; l < NCH; l++) begin
            mode_s[l] = mode[2*l +: 2];
          end
        end else if (in_valid && (cnt_r == CNT_LAST)) begin
          xfer_s      = 1'b1;
          cap_state_s = CAP_IDLE;
          cnt_s       = '0;
        end else if (in_valid) begin
          cnt_s     = cnt_r + CNT_ONE;
          lowzero_s = lowzero_r & ~in_bit;
          for (int l = 0; l < NCH; l++) begin
            cap_s[l] = word_s[l][WIDTH-1:1];
          end
        end else begin
          cap_state_s = CAP_CAPT;
        end
      end
      default: begin
        cap_state_s = CAP_IDLE;
        cnt_s       = '0;
      end
    endcase
  end

  // Output FSM next-state: z tracks "a 1 has been seen", bits after it are inverted when neg
  always_comb begin
    out_state_s = out_state_r;
    ocnt_s      = ocnt_r;
    osh_s       = osh_r;
    oneg_s      = oneg_r;
    oovf_s      = oovf_r;
    z_s         = z_r;
    out_bit_s   = '0;
    out_ovf_s   = '0;
    out_valid_s = 1'b0;
    out_sow_s   = 1'b0;
    out_eow_s   = 1'b0;
    if (xfer_s) begin
      out_state_s = OUT_SEND;
      ocnt_s      = CNT_ONE;
      out_valid_s = 1'b1;
      out_sow_s   = 1'b1;
      oneg_s      = word_neg_s;
      oovf_s      = word_ovf_s;
      for (int l = 0; l < NCH; l++) begin
        osh_s[l]     = word_s[l][WIDTH-1:1];
        out_bit_s[l] = word_s[l][0];
        z_s[l]       = word_s[l][0];
      end
    end else begin
      case (out_state_r)
        OUT_SEND: begin
          if (ocnt_r == CNT_FULL) begin
            out_state_s = OUT_IDLE;
            ocnt_s      = '0;
          end else begin
            out_valid_s = 1'b1;
            ocnt_s      = ocnt_r + CNT_ONE;
            for (int l = 0; l < NCH; l++) begin
              out_bit_s[l] = osh_r[l][0] ^ (oneg_r[l] & z_r[l]);
              z_s[l]       = z_r[l] | osh_r[l][0];
              osh_s[l]     = osh_r[l] >> 1'b1;
            end
            if (ocnt_r == CNT_LAST) begin
              out_eow_s = 1'b1;
              out_ovf_s = oovf_r;
            end else begin
              out_eow_s = 1'b0;
            end
          end
        end
        OUT_IDLE: begin
          out_state_s = OUT_IDLE;
        end
        default: begin
          out_state_s = OUT_IDLE;
          ocnt_s      = '0;
        end
      endcase
    end
  end

  // Capture stage state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_state_r <= CAP_IDLE;
      cnt_r       <= '0;
      cap_r       <= '0;
      lowzero_r   <= '0;
      mode_r      <= '0;
      frame_err_r <= 1'b0;
    end else begin
      cap_state_r <= cap_state_s;
      cnt_r       <= cnt_s;
      cap_r       <= cap_s;
      lowzero_r   <= lowzero_s;
      mode_r      <= mode_s;
      frame_err_r <= abort_s;
    end
  end

  // Output stage state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state_r <= OUT_IDLE;
      ocnt_r      <= '0;
      osh_r       <= '0;
      oneg_r      <= '0;
      oovf_r      <= '0;
      z_r         <= '0;
      out_bit_r   <= '0;
      out_ovf_r   <= '0;
      out_valid_r <= 1'b0;
      out_sow_r   <= 1'b0;
      out_eow_r   <= 1'b0;
    end else begin
      out_state_r <= out_state_s;
      ocnt_r      <= ocnt_s;
      osh_r       <= osh_s;
      oneg_r      <= oneg_s;
      oovf_r      <= oovf_s;
      z_r         <= z_s;
      out_bit_r   <= out_bit_s;
      out_ovf_r   <= out_ovf_s;
      out_valid_r <= out_valid_s;
      out_sow_r   <= out_sow_s;
      out_eow_r   <= out_eow_s;
    end
  end

  assign out_bit   = out_bit_r;
  assign out_valid = out_valid_r;
  assign out_sow   = out_sow_r;
  assign out_eow   = out_eow_r;
  assign out_ovf   = out_ovf_r;
  assign frame_err = frame_err_r;

  serial_tcmp_array_chk #(.NCH(NCH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid_r),
    .out_sow   (out_sow_r),
    .out_eow   (out_eow_r),
    .out_ovf   (out_ovf_r)
  );

endmodule

// File: tb/tb_serial_tcmp_array.sv
// Scoreboard bench for serial_tcmp_array (WIDTH=8, NCH=2): driver pushes expected words
// computed with plain arithmetic, a negedge monitor reassembles output words and compares.

module tb_serial_tcmp_array;
  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int MW  = 2 * NCH;
  localparam logic [W-1:0] MINV = W'(1) << (W - 1);

  logic           clk;
  logic           rst;
  logic [NCH-1:0] in_bit;
  logic           in_valid;
  logic           in_sow;
  logic [MW-1:0]  mode;
  logic [NCH-1:0] out_bit;
  logic           out_valid;
  logic           out_sow;
  logic           out_eow;
  logic [NCH-1:0] out_ovf;
  logic           frame_err;

  typedef logic [NCH-1:0][W-1:0] word_t;
  typedef struct {
    word_t          val;
    logic [NCH-1:0] ovf;
    int             cyc;
  } exp_t;

  exp_t  expq[$];
  int    ferrq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    idx = 0;
  word_t got;

  serial_tcmp_array #(.WIDTH(W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sow    (in_sow),
    .mode      (mode),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_sow   (out_sow),
    .out_eow   (out_eow),
    .out_ovf   (out_ovf),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: negate when mode says so, two's-complement arithmetic modulo 2^W
  function automatic exp_t model(input word_t x, input logic [MW-1:0] m, input int c);
    exp_t e;
    e.cyc = c;
    for (int l = 0; l < NCH; l++) begin
      logic [W-1:0] v;
      logic [1:0]   md;
      bit           neg;
      v   = x[l];
      md  = m[2*l +: 2];
      neg = (md == 2'b01) || ((md == 2'b10) && ($signed(v) < 0));
      e.val[l] = neg ? (W'(0) - v) : v;
      e.ovf[l] = neg && (v == MINV);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return MINV;
      1: return '0;
      2: return MINV - W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic s, input logic [NCH-1:0] b, input logic [MW-1:0] m);
    in_valid = v;
    in_sow   = s;
    in_bit   = b;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit allow_valid);
    for (int k = 0; k < n; k++)
      drive(allow_valid ? 1'($urandom) : 1'b0, 1'b0, NCH'($urandom), MW'($urandom));
    in_valid = 1'b0;
  endtask

  task automatic send_word(input word_t x, input logic [MW-1:0] m, input int stall_at, input int stall_len);
    int t0;
    int st;
    logic [NCH-1:0] b;
    t0 = cyc;
    st = 0;
    for (int i = 0; i < W; i++) begin
      if (i == stall_at && i > 0) begin
        for (int k = 0; k < stall_len; k++) begin
          drive(1'b0, 1'($urandom), NCH'($urandom), MW'($urandom));
          st++;
        end
      end
      for (int l = 0; l < NCH; l++) b[l] = x[l][i];
      drive(1'b1, (i == 0), b, (i == 0) ? m : MW'($urandom));
    end
    in_valid = 1'b0;
    in_sow   = 1'b0;
    expq.push_back(model(x, m, t0 + W + st));
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, (i == 0), NCH'($urandom), MW'($urandom));
    in_valid = 1'b0;
    in_sow   = 1'b0;
  endtask

  // Monitor: frame_err timing, framing flags, reassembly and comparison at eow
  always @(negedge clk) begin
    if (!rst) begin
      idx = 0;
    end else begin
      if (frame_err) begin
        chk(ferrq.size() > 0 && ferrq[0] == cyc, "frame_err_unexpected", 1, 0);
        if (ferrq.size() > 0 && ferrq[0] == cyc) void'(ferrq.pop_front());
      end else if (ferrq.size() > 0 && ferrq[0] <= cyc) begin
        chk(1'b0, "frame_err_missing", 0, 1);
        void'(ferrq.pop_front());
      end
      if (out_valid) begin
        if (idx == 0) begin
          chk(out_sow == 1'b1, "out_sow", out_sow, 1);
          chk(expq.size() > 0, "unexpected_word", expq.size(), 1);
          if (expq.size() > 0) chk(cyc == expq[0].cyc, "sow_latency", cyc, expq[0].cyc);
        end else begin
          chk(out_sow == 1'b0, "out_sow_mid", out_sow, 0);
        end
        for (int l = 0; l < NCH; l++) got[l][idx] = out_bit[l];
        if (idx == W - 1) begin
          chk(out_eow == 1'b1, "out_eow", out_eow, 1);
          if (expq.size() > 0) begin
            chk(out_ovf == expq[0].ovf, "out_ovf", out_ovf, expq[0].ovf);
            chk(got == expq[0].val, "word_value", got, expq[0].val);
            void'(expq.pop_front());
          end
          idx = 0;
        end else begin
          chk(out_eow == 1'b0 && out_ovf == '0, "mid_flags", {out_eow, out_ovf}, 0);
          idx++;
        end
      end else begin
        chk(idx == 0, "gap_in_word", idx, 0);
        chk({out_sow, out_eow, out_ovf} == '0, "idle_flags", {out_sow, out_eow, out_ovf}, 0);
        idx = 0;
      end
    end
  end

  initial begin
    word_t x;
    logic [MW-1:0] m;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sow   = 1'b0;
    in_bit   = '0;
    mode     = '0;
    #2;
    chk({out_bit, out_valid, out_sow, out_eow, out_ovf, frame_err} == '0, "reset_outputs",
        {out_bit, out_valid, out_sow, out_eow, out_ovf, frame_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    send_word({8'h3C, 8'h05}, {2'b00, 2'b01}, -1, 0);
    idle(3, 1'b0);
    send_word({8'h7F, 8'hFB}, {2'b10, 2'b10}, -1, 0);
    send_word({8'h80, 8'h80}, {2'b10, 2'b01}, -1, 0);
    send_word({8'h00, 8'h00}, {2'b01, 2'b01}, -1, 0);
    idle(4, 1'b0);

    send_word({8'h12, 8'h12}, {2'b00, 2'b00}, -1, 0);
    send_word({8'h01, 8'h01}, {2'b01, 2'b01}, -1, 0);
    send_word({8'h90, 8'h90}, {2'b10, 2'b10}, -1, 0);
    idle(4, 1'b0);

    send_word({8'hA5, 8'h80}, {2'b10, 2'b01}, 3, 3);
    idle(2, 1'b0);

    send_partial(4);
    ferrq.push_back(cyc + 1);
    send_word({8'h81, 8'hC3}, {2'b01, 2'b10}, -1, 0);
    idle(W + 2, 1'b1);

    send_word({8'hF0, 8'h0F}, {2'b01, 2'b10}, -1, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk({out_bit, out_valid, out_sow, out_eow, out_ovf, frame_err} == '0, "async_reset_outputs",
        {out_bit, out_valid, out_sow, out_eow, out_ovf, frame_err}, 0);
    expq.delete();
    ferrq.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * W, 1'b1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4), 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        send_partial($urandom_range(1, W - 1));
        ferrq.push_back(cyc + 1);
      end
      x = {rand_val(), rand_val()};
      m = MW'($urandom);
      if ($urandom_range(0, 3) == 0)
        send_word(x, m, $urandom_range(1, W - 1), $urandom_range(1, 4));
      else
        send_word(x, m, -1, 0);
    end

    for (int k = 0; k < 4 * W && expq.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk(expq.size() == 0, "words_drained", expq.size(), 0);
    chk(ferrq.size() == 0, "frame_err_drained", ferrq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tcmp_array.md
Name: serial_tcmp_array

Overview:
- Parametrised, multi-channel, word-framed successor to the single-bit serial two's complementor.
- NCH lanes share one framing. Each lane takes a WIDTH-bit signed word, LSB first, and emits it LSB first after a per-word operation: pass, negate or absolute value.
- A most-negative-value overflow flag is produced per lane.
- Sits between the serial operand sources and the SPM datapath, so that signed operands reach the multiplier in the required form.

Parameters:
WIDTH, 32, word length in bits (>= 2)
NCH, 1, number of parallel serial lanes (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
in_bit  input  NCH  serial data, one bit per lane, LSB first
in_valid  input  1  qualifies in_bit/in_sow; all lanes advance together
in_sow  input  1  start-of-word; marks bit 0 (LSB) of a new word; ignored when in_valid=0
mode  input  2*NCH  per-lane op, sampled at accepted sow: 00 pass, 01 negate, 10 abs, 11 pass
out_bit  output  NCH  serial result, LSB first
out_valid  output  1  out_bit valid this cycle
out_sow  output  1  result bit 0 marker
out_eow  output  1  result bit WIDTH-1 marker
out_ovf  output  NCH  per-lane overflow; meaningful only when out_eow=1, else 0
frame_err  output  1  one-cycle pulse: partial word aborted by a new sow

Behaviour:
- Reset (rst=0, async): all outputs 0; bit counters, capture/output registers, mode and ovf state cleared; capture FSM=IDLE, output FSM=IDLE.

Capture FSM (IDLE, CAPT):
- IDLE: a valid bit without sow is dropped. Accepted sow loads the bit into bit 0, latches mode per lane, sets cnt=1 and moves to CAPT.
- CAPT: each valid bit shifts into a per-lane WIDTH-bit capture register; cnt increments.
- When bit WIDTH-1 is accepted, the word is complete: transfer to the output stage on that edge, then go to IDLE.
- sow accepted in CAPT with cnt<WIDTH: discard the partial word, pulse frame_err, and restart capture with this bit as bit 0 (new mode latched).
- in_valid=0: capture holds and no state changes.

Per-lane flags:
- sign = bit WIDTH-1.
- lowzero = bits 0..WIDTH-2 all 0, tracked during capture.
- neg = (mode==01) | (mode==10 & sign).
- ovf = neg & sign & lowzero (input is -2^(WIDTH-1); result equals input).

Output FSM (IDLE, SEND):
- On transfer: load shift registers, neg and ovf; reset complement flag z=0; go to SEND.
- SEND emits one bit per cycle on consecutive cycles, independent of in_valid, for exactly WIDTH cycles.
  - out_bit = b ^ (neg & z), then z <= z | b. This is the same serial rule as the single-bit complementor.
  - out_sow on bit 0; out_eow and out_ovf on bit WIDTH-1.
- Transfer in the same cycle as bit WIDTH-1 is emitted is legal and gives gapless back-to-back words. Input cannot complete faster than WIDTH cycles, so no overflow/backpressure is possible.
- Outputs are registered. With continuous in_valid, sow accepted in cycle t gives out_sow in cycle t+WIDTH and out_eow in t+2*WIDTH-1. Stalls add their length to the latency.
- ABS/NEG require a full-word buffer because the sign arrives last. PASS uses the same path, giving uniform latency.
- Reset mid-word: everything is cleared. No partial output is emitted afterwards, and the next word needs a fresh sow.

Test Plan:
- WIDTH=8, NCH=2, continuous valid: lane0 0x05 mode NEG, lane1 0x3C PASS, sow at t -> out_sow at t+8; lane0 stream 0xFB, lane1 0x3C; out_ovf=00 at eow.
- ABS: lane0 0xFB -> 0x05; lane1 0x7F -> 0x7F; ovf=00.
- Overflow: lane0 0x80 NEG, lane1 0x80 ABS -> both output 0x80; out_ovf=11 with out_eow; 0x00 NEG -> 0x00, ovf=0.
- Back-to-back: 3 words, no gaps, modes PASS/NEG/ABS, values 0x12/0x01/0x90 -> contiguous 24 out_valid cycles, outputs 0x12, 0xFF, 0x70, sow/eow every 8 cycles.
- Stall/abort: in_valid low 3 cycles mid-word -> out_sow at t+11. Separately, sow at bit 4 of a word -> frame_err pulse, first word never output, second word is output correctly.
- Reset: assert rst=0 during SEND -> all outputs 0 immediately (async). After release, bits without sow are dropped and nothing is output until a new sow arrives.
